// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline controller: stall encodings, masks,
// sequencer state encoding and counter width.
package pipe_ctrl_pkg;

   localparam logic STOP    = 1'b1;
   localparam logic NO_STOP = 1'b0;

   localparam int CNT_W = 5;

   localparam logic [5:0] STALL_NONE = {6{NO_STOP}};
   localparam logic [5:0] STALL_ID   = {{3{NO_STOP}}, {3{STOP}}};
   localparam logic [5:0] STALL_EX   = {{2{NO_STOP}}, {4{STOP}}};

   typedef enum logic [1:0] {
      MC_IDLE = 2'd0,
      MC_RUN  = 2'd1,
      MC_DONE = 2'd2
   } mc_state_e;

endpackage

// File: rtl/pipe_ctrl_mc_timer.sv
// Down-counter for the multi-cycle sequencer: load, decrement, ==1 detect.
module mc_timer
   import pipe_ctrl_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             load,
   input  logic [CNT_W-1:0] load_val,
   input  logic             dec,
   output logic             is_one
);

   logic [CNT_W-1:0] cnt;

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= load_val;
      end else if (dec) begin
         cnt <= cnt - CNT_W'(1);
      end
   end

   assign is_one = (cnt == CNT_W'(1));

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline stall/flush controller with a multi-cycle EX sequencer.
module pipe_ctrl
   import pipe_ctrl_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             stallreq_id,
   input  logic             stallreq_ex,
   input  logic             mc_start,
   input  logic [CNT_W-1:0] mc_len,
   input  logic             flush_req,
   input  logic [31:0]      flush_pc,
   output logic [5:0]       stall,
   output logic             flush,
   output logic [31:0]      new_pc,
   output logic             mc_busy,
   output logic             mc_done
);

   mc_state_e state, state_nxt;
   logic      tmr_load, tmr_dec, tmr_clr, tmr_one;
   logic      ex_stall;

   mc_timer u_timer (
      .clk      (clk),
      .rst      (rst),
      .clr      (tmr_clr),
      .load     (tmr_load),
      .load_val (mc_len - CNT_W'(2)),
      .dec      (tmr_dec),
      .is_one   (tmr_one)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= MC_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Flush is registered so the redirect lands one cycle after the request.
   always_ff @(posedge clk) begin
      if (rst) begin
         flush  <= 1'b0;
         new_pc <= '0;
      end else begin
         flush  <= flush_req;
         new_pc <= flush_req ? flush_pc : 32'd0;
      end
   end

   always_comb begin
      state_nxt = state;
      tmr_load  = 1'b0;
      tmr_dec   = 1'b0;
      tmr_clr   = 1'b0;
      if (flush_req) begin
         state_nxt = MC_IDLE;
         tmr_clr   = 1'b1;
      end else begin
         case (state)
            MC_IDLE: begin
               if (mc_start) begin
                  if (mc_len >= CNT_W'(3)) begin
                     tmr_load  = 1'b1;
                     state_nxt = MC_RUN;
                  end else begin
                     state_nxt = MC_DONE;
                  end
               end
            end
            MC_RUN: begin
               tmr_dec = 1'b1;
               if (tmr_one) state_nxt = MC_DONE;
            end
            MC_DONE: state_nxt = MC_IDLE;
            default: state_nxt = MC_IDLE;
         endcase
      end
   end

   // The start cycle itself stalls EX when the op needs more than one cycle.
   always_comb begin
      ex_stall = stallreq_ex || (state == MC_RUN) ||
                 ((state == MC_IDLE) && mc_start && (mc_len >= CNT_W'(2)));
      if (rst || flush) begin
         stall = STALL_NONE;
      end else if (ex_stall) begin
         stall = STALL_EX;
      end else if (stallreq_id) begin
         stall = STALL_ID;
      end else begin
         stall = STALL_NONE;
      end
   end

   assign mc_busy = !rst && (state != MC_IDLE);
   assign mc_done = !rst && (state == MC_DONE);

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: cycle model plus directed literal checks.
module tb_pipe_ctrl;

   logic        clk = 1'b0;
   logic        rst, stallreq_id, stallreq_ex, mc_start, flush_req;
   logic [4:0]  mc_len;
   logic [31:0] flush_pc;
   logic [5:0]  stall;
   logic        flush, mc_busy, mc_done;
   logic [31:0] new_pc;

   int n_chk  = 0;
   int n_fail = 0;

   // Model: cycles left until the done pulse (0 = idle), and the pending flush.
   int          m_rem   = 0;
   logic        m_flush = 1'b0;
   logic [31:0] m_pc    = 32'd0;

   pipe_ctrl dut (
      .clk         (clk),
      .rst         (rst),
      .stallreq_id (stallreq_id),
      .stallreq_ex (stallreq_ex),
      .mc_start    (mc_start),
      .mc_len      (mc_len),
      .flush_req   (flush_req),
      .flush_pc    (flush_pc),
      .stall       (stall),
      .flush       (flush),
      .new_pc      (new_pc),
      .mc_busy     (mc_busy),
      .mc_done     (mc_done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", nm, got, exp, $time);
      end
   endtask

   always @(posedge clk) begin
      if (rst) begin
         m_rem   = 0;
         m_flush = 1'b0;
         m_pc    = 32'd0;
      end else begin
         m_flush = flush_req;
         m_pc    = flush_req ? flush_pc : 32'd0;
         if (flush_req)       m_rem = 0;
         else if (m_rem > 0)  m_rem = m_rem - 1;
         else if (mc_start)   m_rem = (int'(mc_len) >= 2) ? int'(mc_len) - 1 : 1;
      end
   end

   always @(negedge clk) begin
      logic [5:0] e_stall;
      logic       exs;
      exs = stallreq_ex || (m_rem > 1) || (m_rem == 0 && mc_start && int'(mc_len) >= 2);
      if (rst || m_flush)   e_stall = 6'b000000;
      else if (exs)         e_stall = 6'b001111;
      else if (stallreq_id) e_stall = 6'b000111;
      else                  e_stall = 6'b000000;
      chk("model_stall",   32'(stall),   32'(e_stall));
      chk("model_flush",   32'(flush),   32'(m_flush));
      chk("model_new_pc",  new_pc,       m_pc);
      chk("model_mc_busy", 32'(mc_busy), 32'(!rst && m_rem > 0));
      chk("model_mc_done", 32'(mc_done), 32'(!rst && m_rem == 1));
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      stallreq_id = 0; stallreq_ex = 0; mc_start = 0; mc_len = 0;
      flush_req = 0; flush_pc = 0;
   endtask

   initial begin
      rst = 1'b1;
      idle_inputs();
      cyc(); cyc();
      rst = 1'b0;
      @(negedge clk);
      chk("reset_stall", 32'(stall), 32'h0);
      chk("reset_busy",  32'(mc_busy), 32'h0);
      chk("reset_flush", 32'(flush), 32'h0);
      cyc();

      // Decode and execute stall requests
      stallreq_id = 1;
      @(negedge clk); chk("id_stall", 32'(stall), 32'h07);
      cyc(); stallreq_ex = 1;
      @(negedge clk); chk("id_ex_stall", 32'(stall), 32'h0F);
      cyc(); idle_inputs();

      // Five-cycle op
      mc_start = 1; mc_len = 5;
      @(negedge clk); chk("len5_c1_stall", 32'(stall), 32'h0F); chk("len5_c1_busy", 32'(mc_busy), 32'h0);
      cyc(); idle_inputs();
      for (int i = 2; i <= 4; i++) begin
         @(negedge clk);
         chk("len5_run_stall", 32'(stall), 32'h0F);
         chk("len5_run_busy", 32'(mc_busy), 32'h1);
         chk("len5_run_done", 32'(mc_done), 32'h0);
         cyc();
      end
      @(negedge clk); chk("len5_c5_done", 32'(mc_done), 32'h1); chk("len5_c5_stall", 32'(stall), 32'h0);
      cyc();
      @(negedge clk); chk("len5_c6_busy", 32'(mc_busy), 32'h0);
      cyc();

      // One- and two-cycle ops
      mc_start = 1; mc_len = 1;
      @(negedge clk); chk("len1_stall", 32'(stall), 32'h0);
      cyc(); idle_inputs();
      @(negedge clk); chk("len1_done", 32'(mc_done), 32'h1);
      cyc();
      mc_start = 1; mc_len = 2;
      @(negedge clk); chk("len2_stall", 32'(stall), 32'h0F);
      cyc(); idle_inputs();
      @(negedge clk); chk("len2_done", 32'(mc_done), 32'h1); chk("len2_stall2", 32'(stall), 32'h0);
      cyc(); cyc();

      // Flush during the second RUN cycle of a five-cycle op
      mc_start = 1; mc_len = 5;
      cyc(); idle_inputs();
      cyc();
      flush_req = 1; flush_pc = 32'hBFC00380;
      cyc(); idle_inputs();
      @(negedge clk);
      chk("flush_pulse", 32'(flush), 32'h1);
      chk("flush_pc",    new_pc, 32'hBFC00380);
      chk("flush_stall", 32'(stall), 32'h0);
      chk("flush_busy",  32'(mc_busy), 32'h0);
      chk("flush_done",  32'(mc_done), 32'h0);
      cyc();
      @(negedge clk); chk("flush_after", 32'(flush), 32'h0); chk("flush_pc_clr", new_pc, 32'h0);
      chk("flush_nodone", 32'(mc_done), 32'h0);
      cyc();

      // Flush and start together: start is dropped
      flush_req = 1; flush_pc = 32'h0000_1234; mc_start = 1; mc_len = 4;
      cyc(); idle_inputs();
      @(negedge clk); chk("fs_flush", 32'(flush), 32'h1); chk("fs_busy", 32'(mc_busy), 32'h0);
      cyc();
      @(negedge clk); chk("fs_busy2", 32'(mc_busy), 32'h0); chk("fs_stall2", 32'(stall), 32'h0);
      cyc();

      // Back-to-back flushes carry their own targets
      flush_req = 1; flush_pc = 32'hAAAA_0001;
      cyc(); flush_pc = 32'h5555_0002;
      @(negedge clk); chk("b2b_pc1", new_pc, 32'hAAAA_0001);
      cyc(); idle_inputs();
      @(negedge clk); chk("b2b_flush2", 32'(flush), 32'h1); chk("b2b_pc2", new_pc, 32'h5555_0002);
      cyc();

      // Reset mid-RUN, then a fresh op
      mc_start = 1; mc_len = 8;
      cyc(); idle_inputs(); stallreq_ex = 1;
      cyc(); rst = 1;
      @(negedge clk); chk("rst_stall", 32'(stall), 32'h0); chk("rst_busy", 32'(mc_busy), 32'h0);
      cyc(); rst = 0; idle_inputs();
      @(negedge clk);
      chk("postrst_busy", 32'(mc_busy), 32'h0);
      chk("postrst_done", 32'(mc_done), 32'h0);
      chk("postrst_flush", 32'(flush), 32'h0);
      chk("postrst_pc", new_pc, 32'h0);
      chk("postrst_stall", 32'(stall), 32'h0);
      mc_start = 1; mc_len = 2;
      #1; chk("fresh_stall", 32'(stall), 32'h0F);
      cyc(); idle_inputs();
      @(negedge clk); chk("fresh_done", 32'(mc_done), 32'h1); chk("fresh_busy", 32'(mc_busy), 32'h1);
      cyc();

      // External stall while sequencing does not disturb the count
      mc_start = 1; mc_len = 4;
      cyc(); idle_inputs(); stallreq_ex = 1;
      cyc(); cyc();
      @(negedge clk); chk("ext_done", 32'(mc_done), 32'h1); chk("ext_stall", 32'(stall), 32'h0F);
      cyc(); idle_inputs();
      cyc(); cyc();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 SHALL have ports: clk, input, 1, clock, rising edge.
REQ-002 SHALL have ports: rst, input, 1, reset (synchronous, active-high).
REQ-003 SHALL have ports: stallreq_id, input, 1, decode-stage hazard stall request.
REQ-004 SHALL have ports: stallreq_ex, input, 1, external execute-stage stall request.
REQ-005 SHALL have ports: mc_start, input, 1, EX begins a multi-cycle op this cycle.
REQ-006 SHALL have ports: mc_len, input, 5, total EX occupancy in cycles of that op.
REQ-007 SHALL have ports: flush_req, input, 1, exception/redirect request.
REQ-008 SHALL have ports: flush_pc, input, 32, redirect target.
REQ-009 SHALL have ports: stall, output, 6, per-stage freeze: bit0 pc, bit1 if, bit2 id, bit3 ex, bit4 mem, bit5 wb; 1 = Stop.
REQ-010 SHALL have ports: flush, output, 1, one-cycle pipeline flush pulse.
REQ-011 SHALL have ports: new_pc, output, 32, redirect target, valid while flush=1.
REQ-012 SHALL have ports: mc_busy, output, 1, multi-cycle sequencer not IDLE.
REQ-013 SHALL have ports: mc_done, output, 1, one-cycle completion pulse.

Function
REQ-014 SHALL drive stall combinationally from the current state and inputs.
REQ-015 SHALL apply stall priority: flush=1 gives 6'b000000; else EX stall gives 6'b001111; else stallreq_id gives 6'b000111; else 6'b000000.
REQ-016 SHALL define EX stall as stallreq_ex, OR state RUN, OR (state IDLE and mc_start and mc_len>=2).
REQ-017 SHALL implement FSM states IDLE, RUN and DONE.
REQ-018 SHALL, from IDLE with mc_start and mc_len>=3, load cnt=mc_len-2 and go to RUN.
REQ-019 SHALL, from IDLE with mc_start and mc_len in {0,1,2}, go directly to DONE.
REQ-020 SHALL, in RUN, decrement cnt each cycle and go to DONE when cnt==1.
REQ-021 SHALL assert EX stall for exactly mc_len-1 consecutive cycles, counting the mc_start cycle (zero cycles for mc_len<=1).
REQ-022 SHALL assert mc_done only in DONE, for one cycle, then return to IDLE.
REQ-023 SHALL ignore mc_start outside IDLE.
REQ-024 SHALL assert mc_busy whenever state is not IDLE.
REQ-025 SHALL register flush_req: flush=1 and new_pc=flush_pc exactly one cycle after flush_req is sampled high.
REQ-026 SHALL force the FSM to IDLE and cnt to 0 on the edge where flush_req is sampled, with no mc_done issued for the aborted op.
REQ-027 SHALL pulse flush once per flush_req=1 cycle; back-to-back requests give back-to-back pulses, each carrying its own flush_pc.
REQ-028 SHALL hold new_pc at 0 whenever flush=0.
REQ-029 SHALL let flush_req take precedence over a simultaneous mc_start, which is then dropped.
REQ-030 SHALL let stallreq_id/stallreq_ex not alter FSM state or cnt; the sequencer keeps counting during an external stall.

Reset
REQ-031 SHALL, with rst high at a clock edge, set state=IDLE, cnt=0, flush=0, new_pc=0 and mc_done=0.
REQ-032 SHALL give stall=0 and mc_busy=0 while reset is in effect; inputs have no effect during reset, and an in-progress op is abandoned.

Structure
REQ-033 SHALL take Stop/NoStop, the stall masks (000111, 001111), FSM state encodings and the 5-bit cnt width from the shared define package.
REQ-034 SHALL place the down-counter (load, decrement, ==1 detect) in one sub-module, mc_timer.

Verification
REQ-035 SHALL cover: stallreq_id=1 alone -> stall=000111; with stallreq_ex=1 also -> 001111.
REQ-036 SHALL cover: mc_start with mc_len=5 from IDLE -> stall=001111 for 4 cycles, mc_done in cycle 5, mc_busy high for cycles 2-5.
REQ-037 SHALL cover: mc_len=1 -> no stall, mc_done next cycle; mc_len=2 -> 1 stall cycle, then mc_done.
REQ-038 SHALL cover: flush_req with flush_pc=0xBFC00380 in the 2nd RUN cycle -> next cycle flush=1, new_pc=0xBFC00380, stall=0, mc_busy=0, no mc_done.
REQ-039 SHALL cover: flush_req and mc_start in the same cycle -> flush pulse only, FSM stays IDLE.
REQ-040 SHALL cover: rst asserted mid-RUN -> all outputs 0 next cycle, and a fresh mc_start is accepted after rst deasserts.
